// File: rtl/addr_seq_ctrl.sv
// addr_seq_ctrl: programmable address sequencer.
//
// Walks addr across the window [base_addr, limit_addr] in steps of `step`,
// counting up from base or down from limit, in one-shot, wrap or ping-pong
// mode. The configuration is latched on start; the live inputs are ignored
// until the next start.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   start      1-cycle pulse: validate/latch configuration, begin a pass
//   stop       abort the current run, return to idle (addr holds)
//   advance    step enable, honoured only while running
//   base_addr  lower window bound (inclusive)
//   limit_addr upper window bound (inclusive)
//   step       increment size, 0 treated as 1
//   dir        0 = up from base, 1 = down from limit
//   mode       00 one-shot, 01 wrap, 10 ping-pong, 11 one-shot
//   addr       current address (registered)
//   busy       high while running (registered)
//   done       1-cycle pulse at end of a one-shot pass
//   wrapped    1-cycle pulse on each wrap or ping-pong turnaround
//   cfg_err    1-cycle pulse when start is rejected (base > limit)
module addr_seq_ctrl #(
    parameter int unsigned AW = 8,
    parameter int unsigned SW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          stop,
    input  logic          advance,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] limit_addr,
    input  logic [SW-1:0] step,
    input  logic          dir,
    input  logic [1:0]    mode,
    output logic [AW-1:0] addr,
    output logic          busy,
    output logic          done,
    output logic          wrapped,
    output logic          cfg_err
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    localparam logic [1:0] ModeWrap     = 2'b01;
    localparam logic [1:0] ModePingPong = 2'b10;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW-1:0] limit_q, limit_d;
    logic [SW-1:0] step_q, step_d;
    logic [1:0]    mode_q, mode_d;
    logic          dir_q, dir_d;
    logic          busy_q;
    logic          done_q, done_d;
    logic          wrapped_q, wrapped_d;
    logic          cfg_err_q, cfg_err_d;

    // Arithmetic is one bit wider than the address so an overshoot past the
    // top of the address space or a borrow below zero is visible, not wrapped.
    logic [AW:0] step_ext;
    logic [AW:0] cand;
    logic        end_of_pass;

    assign step_ext = (AW+1)'(step_q);

    always_comb begin
        if (dir_q) begin
            cand        = {1'b0, addr_q} - step_ext;
            end_of_pass = cand[AW] || (cand[AW-1:0] < base_q);
        end else begin
            cand        = {1'b0, addr_q} + step_ext;
            end_of_pass = cand > {1'b0, limit_q};
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            base_q    <= '0;
            limit_q   <= '0;
            step_q    <= '0;
            mode_q    <= '0;
            dir_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wrapped_q <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            base_q    <= base_d;
            limit_q   <= limit_d;
            step_q    <= step_d;
            mode_q    <= mode_d;
            dir_q     <= dir_d;
            busy_q    <= (state_d == StRun);
            done_q    <= done_d;
            wrapped_q <= wrapped_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Next-state logic. Priority: stop > start > advance.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        base_d    = base_q;
        limit_d   = limit_q;
        step_d    = step_q;
        mode_d    = mode_q;
        dir_d     = dir_q;
        done_d    = 1'b0;
        wrapped_d = 1'b0;
        cfg_err_d = 1'b0;

        if (stop) begin
            state_d = StIdle;
        end else if (start) begin
            if (base_addr > limit_addr) begin
                state_d   = StIdle;
                cfg_err_d = 1'b1;
            end else begin
                state_d = StRun;
                base_d  = base_addr;
                limit_d = limit_addr;
                step_d  = (step == '0) ? SW'(1) : step;
                mode_d  = mode;
                dir_d   = dir;
                addr_d  = dir ? limit_addr : base_addr;
            end
        end else if (state_q == StRun && advance) begin
            if (!end_of_pass) begin
                addr_d = cand[AW-1:0];
            end else if (mode_q == ModeWrap) begin
                addr_d    = dir_q ? limit_q : base_q;
                wrapped_d = 1'b1;
            end else if (mode_q == ModePingPong) begin
                // Turn around in place: addr dwells one tick at the endpoint.
                dir_d     = ~dir_q;
                wrapped_d = 1'b1;
            end else begin
                state_d = StIdle;
                done_d  = 1'b1;
            end
        end
    end

    // Outputs are straight from registers.
    always_comb begin
        addr    = addr_q;
        busy    = busy_q;
        done    = done_q;
        wrapped = wrapped_q;
        cfg_err = cfg_err_q;
    end

endmodule
